control_unit: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 75 +++++++
 rtl/control_unit_branch_eval.sv | 26 ++
 rtl/control_unit.sv | 145 ++++++++++++++
 tb/tb_control_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S encodings: instruction decode, control FSM states, ALU op codes
// and the control-strobe bundle driven by control_unit.
package k_and_s_pkg;

    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        RST       = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        LOAD_S    = 4'd3,
        STORE_S   = 4'd4,
        MOVE_S    = 4'd5,
        ALU_S     = 4'd6,
        BRANCH_S  = 4'd7,
        HALT_S    = 4'd8,
        STEP_WAIT = 4'd9
    } ctrl_state_type;

    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b11;

    typedef struct packed {
        logic                halt;
        logic                branch;
        logic                pc_enable;
        logic                ir_enable;
        logic                addr_sel;
        logic                c_sel;
        logic [ALU_OP_W-1:0] operation;
        logic                write_reg_enable;
        logic                flags_reg_enable;
        logic                ram_write_enable;
    } ctrl_bus_type;

    function automatic logic is_branch(input decoded_instruction_type instr);
        return (instr >= I_BRANCH) && (instr <= I_BNOV);
    endfunction

    function automatic logic is_alu(input decoded_instruction_type instr);
        return (instr >= I_ADD) && (instr <= I_OR);
    endfunction

    // Unknown opcodes map to OR, which is also the MOVE pass-through op.
    function automatic logic [ALU_OP_W-1:0] alu_op_of(input decoded_instruction_type instr);
        case (instr)
            I_ADD:   return ALU_ADD;
            I_SUB:   return ALU_SUB;
            I_AND:   return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Combinational taken/not-taken decision for the K&S conditional branches.
module branch_eval
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    signed_overflow,
    output logic                    taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (decoded_instruction)
            I_BRANCH: taken_c = 1'b1;
            I_BZERO:  taken_c = zero_op;
            I_BNZERO: taken_c = ~zero_op;
            I_BNEG:   taken_c = neg_op;
            I_BNNEG:  taken_c = ~neg_op;
            I_BOV:    taken_c = signed_overflow;
            I_BNOV:   taken_c = ~signed_overflow;
            default:  taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// K&S multi-cycle control FSM: fetch, decode, execute; drives datapath strobes.
// Optional single-step mode (step input, STEP_WAIT state) under KS_SINGLE_STEP_EN.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef KS_SINGLE_STEP_EN
    input  logic                    step,
`endif
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [ALU_OP_W-1:0]     operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    // Where an instruction goes once it has finished executing.
`ifdef KS_SINGLE_STEP_EN
    localparam ctrl_state_type NEXT_FETCH = STEP_WAIT;
`else
    localparam ctrl_state_type NEXT_FETCH = FETCH;
`endif

    ctrl_state_type state, state_next;
    ctrl_bus_type   ctrl_c;
    logic           taken_c;

    // The branch logic only looks at the signed flags.
    logic unused_flags;
    assign unused_flags = unsigned_overflow;

    branch_eval u_branch_eval (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .signed_overflow     (signed_overflow),
        .taken_c             (taken_c)
    );

    // Async reset: strobes are decoded from state, so they drop with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctrl_c     = '0;
        case (state)
            RST: begin
                state_next = FETCH;
            end
            FETCH: begin
                ctrl_c.addr_sel  = 1'b1;
                ctrl_c.ir_enable = 1'b1;
                ctrl_c.pc_enable = 1'b1;
                state_next       = DECODE;
            end
            DECODE: begin
                if (decoded_instruction == I_LOAD) begin
                    state_next = LOAD_S;
                end else if (decoded_instruction == I_STORE) begin
                    state_next = STORE_S;
                end else if (decoded_instruction == I_MOVE) begin
                    state_next = MOVE_S;
                end else if (is_alu(decoded_instruction)) begin
                    state_next = ALU_S;
                end else if (is_branch(decoded_instruction)) begin
                    state_next = BRANCH_S;
                end else if (decoded_instruction == I_HALT) begin
                    state_next = HALT_S;
                end else begin
                    state_next = NEXT_FETCH;
                end
            end
            LOAD_S: begin
                ctrl_c.write_reg_enable = 1'b1;
                state_next              = NEXT_FETCH;
            end
            STORE_S: begin
                ctrl_c.ram_write_enable = 1'b1;
                state_next              = NEXT_FETCH;
            end
            MOVE_S: begin
                ctrl_c.operation        = ALU_OR;
                ctrl_c.c_sel            = 1'b1;
                ctrl_c.write_reg_enable = 1'b1;
                state_next              = NEXT_FETCH;
            end
            ALU_S: begin
                ctrl_c.operation        = alu_op_of(decoded_instruction);
                ctrl_c.c_sel            = 1'b1;
                ctrl_c.write_reg_enable = 1'b1;
                ctrl_c.flags_reg_enable = 1'b1;
                state_next              = NEXT_FETCH;
            end
            BRANCH_S: begin
                // Not taken needs no strobe: PC already advanced in FETCH.
                ctrl_c.pc_enable = taken_c;
                ctrl_c.branch    = taken_c;
                state_next       = NEXT_FETCH;
            end
            HALT_S: begin
                ctrl_c.halt = 1'b1;
                state_next  = HALT_S;
            end
`ifdef KS_SINGLE_STEP_EN
            STEP_WAIT: begin
                if (step) begin
                    state_next = FETCH;
                end
            end
`endif
            default: begin
                state_next = RST;
            end
        endcase
    end

    assign halt             = ctrl_c.halt;
    assign branch           = ctrl_c.branch;
    assign pc_enable        = ctrl_c.pc_enable;
    assign ir_enable        = ctrl_c.ir_enable;
    assign addr_sel         = ctrl_c.addr_sel;
    assign c_sel            = ctrl_c.c_sel;
    assign operation        = ctrl_c.operation;
    assign write_reg_enable = ctrl_c.write_reg_enable;
    assign flags_reg_enable = ctrl_c.flags_reg_enable;
    assign ram_write_enable = ctrl_c.ram_write_enable;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expected strobes,
// a negedge monitor pops and compares them against the DUT.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    decoded_instruction_type decoded_instruction = I_NOP;
    logic zero_op = 1'b0;
    logic neg_op = 1'b0;
    logic unsigned_overflow = 1'b0;
    logic signed_overflow = 1'b0;
`ifdef KS_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
`ifdef KS_SINGLE_STEP_EN
        .step                (step),
`endif
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    always #5 clk = ~clk;

    // {halt, branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wre, fre, rwe}
    logic [10:0] act;
    assign act = {halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                  write_reg_enable, flags_reg_enable, ram_write_enable};

    localparam logic [10:0] E_NONE    = 11'b0_0_0_0_0_0_00_0_0_0;
    localparam logic [10:0] E_FETCH   = 11'b0_0_1_1_1_0_00_0_0_0;
    localparam logic [10:0] E_LOAD    = 11'b0_0_0_0_0_0_00_1_0_0;
    localparam logic [10:0] E_STORE   = 11'b0_0_0_0_0_0_00_0_0_1;
    localparam logic [10:0] E_MOVE    = 11'b0_0_0_0_0_1_00_1_0_0;
    localparam logic [10:0] E_ADD     = 11'b0_0_0_0_0_1_01_1_1_0;
    localparam logic [10:0] E_SUB     = 11'b0_0_0_0_0_1_10_1_1_0;
    localparam logic [10:0] E_AND     = 11'b0_0_0_0_0_1_11_1_1_0;
    localparam logic [10:0] E_OR      = 11'b0_0_0_0_0_1_00_1_1_0;
    localparam logic [10:0] E_BR_TKN  = 11'b0_1_1_0_0_0_00_0_0_0;
    localparam logic [10:0] E_HALT    = 11'b1_0_0_0_0_0_00_0_0_0;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    string       name_q[$];

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endfunction

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {21'b0, act}, {21'b0, e});
        end
    end

    // Called at posedge+1: queue the expectation for this cycle, advance one clock.
    task automatic cyc(input string nm, input logic [10:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string nm, input decoded_instruction_type instr,
                             input logic has_exec, input logic [10:0] e_exec);
        decoded_instruction = instr;
        cyc({nm, "_fetch"}, E_FETCH);
        cyc({nm, "_decode"}, E_NONE);
        if (has_exec) cyc({nm, "_exec"}, e_exec);
`ifdef KS_SINGLE_STEP_EN
        if (instr != I_HALT) cyc({nm, "_stepwait"}, E_NONE);
`endif
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_held", E_NONE);
        rst_n = 1'b1;
        cyc("reset_bubble", E_NONE);

        run_instr("add", I_ADD, 1'b1, E_ADD);
        run_instr("sub", I_SUB, 1'b1, E_SUB);
        run_instr("and", I_AND, 1'b1, E_AND);
        run_instr("or", I_OR, 1'b1, E_OR);
        run_instr("move", I_MOVE, 1'b1, E_MOVE);
        run_instr("load", I_LOAD, 1'b1, E_LOAD);
        run_instr("store", I_STORE, 1'b1, E_STORE);
        run_instr("nop", I_NOP, 1'b0, E_NONE);

        zero_op = 1'b1;
        run_instr("bzero_z1", I_BZERO, 1'b1, E_BR_TKN);
        zero_op = 1'b0;
        run_instr("bzero_z0", I_BZERO, 1'b1, E_NONE);
        run_instr("bnzero_z0", I_BNZERO, 1'b1, E_BR_TKN);
        neg_op = 1'b0;
        run_instr("bnneg_n0", I_BNNEG, 1'b1, E_BR_TKN);
        neg_op = 1'b1;
        run_instr("bneg_n1", I_BNEG, 1'b1, E_BR_TKN);
        signed_overflow = 1'b0;
        unsigned_overflow = 1'b1;
        run_instr("bov_s0_u1", I_BOV, 1'b1, E_NONE);
        signed_overflow = 1'b1;
        run_instr("bov_s1", I_BOV, 1'b1, E_BR_TKN);
        run_instr("bnov_s1", I_BNOV, 1'b1, E_NONE);
        run_instr("branch", I_BRANCH, 1'b1, E_BR_TKN);

        // Reset during ALU_S must drop write_reg_enable without a clock edge.
        decoded_instruction = I_ADD;
        cyc("rst_add_fetch", E_FETCH);
        cyc("rst_add_decode", E_NONE);
        check("alu_s_wre_before_rst", {31'b0, write_reg_enable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("alu_s_wre_async_drop", {31'b0, write_reg_enable}, 32'd0);
        check("alu_s_all_async_drop", {21'b0, act}, {21'b0, E_NONE});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_mid_bubble", E_NONE);
        run_instr("add_after_rst", I_ADD, 1'b1, E_ADD);

        // HALT is sticky until rst_n.
        run_instr("halt", I_HALT, 1'b1, E_HALT);
        for (int i = 0; i < 20; i++) cyc("halt_sticky", E_HALT);
        rst_n = 1'b0;
        cyc("halt_rst_held", E_NONE);
        rst_n = 1'b1;
        cyc("halt_rst_bubble", E_NONE);
        run_instr("load_after_halt", I_LOAD, 1'b1, E_LOAD);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
